// File: rtl/cv_frame_smoother_pkg.sv
// Shared definitions for the CV frame smoother: widths, channel count and FSM states.
package cv_pkg;

  localparam int CV_WIDTH    = 16;
  localparam int CV_CHANNELS = 4;
  localparam int OVR_WIDTH   = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILTER  = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

endpackage

// File: rtl/cv_frame_smoother_sync_edge_detect.sv
// Two-flop synchroniser for a flag from a foreign clock domain, plus a third
// flop that turns the synchronised level into a single-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;

  // Next-state of the synchroniser chain: a plain shift of the async level.
  always_comb begin
    sync1_d = i_Async;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  // Synchroniser and edge-history flops.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  assign o_Pulse = sync2_q & ~sync3_q;

endmodule

// File: rtl/cv_frame_smoother.sv
// Captures CV frames from the SPI receiver, smooths each channel with a
// one-pole IIR on a single shared datapath, and publishes with a valid strobe.
// Also tracks dropped frames and a stale-input watchdog.
module cv_frame_smoother
  import cv_pkg::*;
#(
  parameter int CHANNELS       = CV_CHANNELS,
  parameter int DATA_WIDTH     = CV_WIDTH,
  parameter int SMOOTH_SHIFT   = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Data_Received,
  input  logic [DATA_WIDTH-1:0] i_Data0,
  input  logic [DATA_WIDTH-1:0] i_Data1,
  input  logic [DATA_WIDTH-1:0] i_Data2,
  input  logic [DATA_WIDTH-1:0] i_Data3,
  output logic [DATA_WIDTH-1:0] o_CV0,
  output logic [DATA_WIDTH-1:0] o_CV1,
  output logic [DATA_WIDTH-1:0] o_CV2,
  output logic [DATA_WIDTH-1:0] o_CV3,
  output logic                  o_Valid,
  output logic                  o_Primed,
  output logic                  o_Stale,
  output logic [OVR_WIDTH-1:0]  o_Overrun_Count
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [DATA_WIDTH-1:0]  raw_q [CHANNELS];
  logic [DATA_WIDTH-1:0]  raw_d [CHANNELS];
  logic [DATA_WIDTH-1:0]  acc_q [CHANNELS];
  logic [DATA_WIDTH-1:0]  acc_d [CHANNELS];
  logic [DATA_WIDTH-1:0]  cv_q  [CHANNELS];
  logic [DATA_WIDTH-1:0]  cv_d  [CHANNELS];
  logic                   valid_q, valid_d;
  logic                   primed_q, primed_d;
  logic                   stale_q, stale_d;
  logic [OVR_WIDTH-1:0]   ovr_q, ovr_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic                   accept_s;
  logic [DATA_WIDTH-1:0]  raw_sel_s;
  logic [DATA_WIDTH-1:0]  acc_sel_s;
  logic signed [DATA_WIDTH:0] diff_s;
  logic signed [DATA_WIDTH:0] step_s;
  logic signed [DATA_WIDTH:0] sum_s;
  logic [DATA_WIDTH-1:0]  acc_new_s;
  logic                   unused_carry_s;

  sync_edge_detect u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Data_Received),
    .o_Pulse (accept_s)
  );

  // Shared filter datapath: the result lies between acc and raw, so the
  // dropped carry bit never matters. Unprimed frames load raw directly.
  always_comb begin
    raw_sel_s = raw_q[ch_q];
    acc_sel_s = acc_q[ch_q];
    diff_s    = $signed({1'b0, raw_sel_s}) - $signed({1'b0, acc_sel_s});
    step_s    = diff_s >>> SMOOTH_SHIFT;
    sum_s     = $signed({1'b0, acc_sel_s}) + step_s;
    unused_carry_s = sum_s[DATA_WIDTH];
    if (primed_q) begin
      acc_new_s = sum_s[DATA_WIDTH-1:0];
    end else begin
      acc_new_s = raw_sel_s;
    end
  end

  // FSM next-state, watchdog, overrun counting and output staging.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    raw_d    = raw_q;
    acc_d    = acc_q;
    cv_d     = cv_q;
    valid_d  = 1'b0;
    primed_d = primed_q;
    stale_d  = stale_q;
    ovr_d    = ovr_q;

    if (wd_q == WD_MAX) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
    if (wd_d == WD_MAX) begin
      stale_d = 1'b1;
    end else begin
      stale_d = stale_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          raw_d[0] = i_Data0;
          raw_d[1] = i_Data1;
          raw_d[2] = i_Data2;
          raw_d[3] = i_Data3;
          ch_d     = CH_W'(0);
          wd_d     = WD_W'(0);
          state_d  = S_FILTER;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_FILTER: begin
        acc_d[ch_q] = acc_new_s;
        if (ch_q == CH_LAST) begin
          state_d = S_PUBLISH;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      S_PUBLISH: begin
        cv_d     = acc_q;
        valid_d  = 1'b1;
        primed_d = 1'b1;
        stale_d  = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A frame arriving while busy is dropped and counted.
    if (accept_s && (state_q != S_IDLE) && (ovr_q != {OVR_WIDTH{1'b1}})) begin
      ovr_d = ovr_q + OVR_WIDTH'(1);
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
      stale_q  <= 1'b0;
      ovr_q    <= '0;
      wd_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        raw_q[i] <= '0;
        acc_q[i] <= '0;
        cv_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
      stale_q  <= stale_d;
      ovr_q    <= ovr_d;
      wd_q     <= wd_d;
      raw_q    <= raw_d;
      acc_q    <= acc_d;
      cv_q     <= cv_d;
    end
  end

  assign o_CV0           = cv_q[0];
  assign o_CV1           = cv_q[1];
  assign o_CV2           = cv_q[2];
  assign o_CV3           = cv_q[3];
  assign o_Valid         = valid_q;
  assign o_Primed        = primed_q;
  assign o_Stale         = stale_q;
  assign o_Overrun_Count = ovr_q;

endmodule

// File: tb/tb_cv_frame_smoother.sv
// Scoreboard bench for cv_frame_smoother: stimulus pushes hand-computed
// expected publishes; a monitor pops and compares on every o_Valid.
module tb_cv_frame_smoother;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Data_Received = 1'b0;
  logic [15:0] i_Data0 = 16'h0, i_Data1 = 16'h0, i_Data2 = 16'h0, i_Data3 = 16'h0;
  logic [15:0] o_CV0, o_CV1, o_CV2, o_CV3;
  logic        o_Valid, o_Primed, o_Stale;
  logic [7:0]  o_Overrun_Count;

  typedef struct {
    logic [15:0] cv0, cv1, cv2, cv3;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  cv_frame_smoother #(.SMOOTH_SHIFT(2), .TIMEOUT_CYCLES(100)) dut (
    .i_Clock         (i_Clock),
    .i_Reset         (i_Reset),
    .i_Data_Received (i_Data_Received),
    .i_Data0         (i_Data0),
    .i_Data1         (i_Data1),
    .i_Data2         (i_Data2),
    .i_Data3         (i_Data3),
    .o_CV0           (o_CV0),
    .o_CV1           (o_CV1),
    .o_CV2           (o_CV2),
    .o_CV3           (o_CV3),
    .o_Valid         (o_Valid),
    .o_Primed        (o_Primed),
    .o_Stale         (o_Stale),
    .o_Overrun_Count (o_Overrun_Count)
  );

  initial forever #5 i_Clock = ~i_Clock;

  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] e0, e1, e2, e3, input int c);
    exp_t e;
    e.cv0 = e0; e.cv1 = e1; e.cv2 = e2; e.cv3 = e3; e.cyc = c;
    sb.push_back(e);
  endtask

  // Normal frame: flag high for 3 cycles; publish expected 8 counter ticks later.
  task automatic send_frame(input logic [15:0] d0, d1, d2, d3,
                            input logic [15:0] e0, e1, e2, e3);
    @(negedge i_Clock);
    i_Data0 = d0; i_Data1 = d1; i_Data2 = d2; i_Data3 = d3;
    i_Data_Received = 1'b1;
    push_exp(e0, e1, e2, e3, cyc + 8);
    repeat (3) @(negedge i_Clock);
    i_Data_Received = 1'b0;
    repeat (12) @(negedge i_Clock);
  endtask

  // Frame followed by a second flag edge that lands while the filter is busy.
  task automatic send_overrun_frame(input logic [15:0] d0, d1, d2, d3);
    @(negedge i_Clock);
    i_Data0 = d0; i_Data1 = d1; i_Data2 = d2; i_Data3 = d3;
    i_Data_Received = 1'b1;
    push_exp(d0, d1, d2, d3, cyc + 8);
    @(negedge i_Clock); i_Data_Received = 1'b0;
    repeat (2) @(negedge i_Clock);
    i_Data_Received = 1'b1;
    @(negedge i_Clock); i_Data_Received = 1'b0;
    repeat (12) @(negedge i_Clock);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cv0"}, {16'h0, o_CV0}, 32'h0);
    check({tag, "_cv1"}, {16'h0, o_CV1}, 32'h0);
    check({tag, "_cv2"}, {16'h0, o_CV2}, 32'h0);
    check({tag, "_cv3"}, {16'h0, o_CV3}, 32'h0);
    check({tag, "_valid"}, {31'h0, o_Valid}, 32'h0);
    check({tag, "_primed"}, {31'h0, o_Primed}, 32'h0);
    check({tag, "_stale"}, {31'h0, o_Stale}, 32'h0);
    check({tag, "_ovr"}, {24'h0, o_Overrun_Count}, 32'h0);
  endtask

  // Monitor: every o_Valid cycle must match the oldest expected publish.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_Clock);
      if (o_Valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          check("pub_cv0", {16'h0, o_CV0}, {16'h0, e.cv0});
          check("pub_cv1", {16'h0, o_CV1}, {16'h0, e.cv1});
          check("pub_cv2", {16'h0, o_CV2}, {16'h0, e.cv2});
          check("pub_cv3", {16'h0, o_CV3}, {16'h0, e.cv3});
          check("pub_cycle", cyc, e.cyc);
          check("pub_primed", {31'h0, o_Primed}, 32'h1);
          check("pub_stale", {31'h0, o_Stale}, 32'h0);
        end
      end
    end
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    i_Reset = 1'b1;
    repeat (3) @(negedge i_Clock);
    i_Reset = 1'b0;
    check_zero("reset");

    // First frame loads directly
    send_frame(16'h1000, 16'h2000, 16'h3000, 16'h4000,
               16'h1000, 16'h2000, 16'h3000, 16'h4000);
    check("primed_after_first", {31'h0, o_Primed}, 32'h1);

    // Smoothing up/down with shift 2
    send_frame(16'h2000, 16'h2000, 16'h3000, 16'h0000,
               16'h1400, 16'h2000, 16'h3000, 16'h3000);
    send_frame(16'h2000, 16'h2000, 16'h3000, 16'h0000,
               16'h1700, 16'h2000, 16'h3000, 16'h2400);
    send_frame(16'h2000, 16'h2000, 16'h3000, 16'h0000,
               16'h1940, 16'h2000, 16'h3000, 16'h1B00);
    check("held_cv0", {16'h0, o_CV0}, 32'h1940);

    // Reset in the middle of filtering: no publish, everything cleared
    @(negedge i_Clock);
    i_Data0 = 16'h1234; i_Data1 = 16'h1234; i_Data2 = 16'h1234; i_Data3 = 16'h1234;
    i_Data_Received = 1'b1;
    repeat (3) @(negedge i_Clock);
    i_Data_Received = 1'b0;
    @(negedge i_Clock);
    i_Reset = 1'b1;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    check_zero("midreset");
    repeat (15) @(negedge i_Clock);

    // Post-reset frame loads directly, then boundary steps
    send_frame(16'h8000, 16'h1000, 16'hFFF0, 16'h0003,
               16'h8000, 16'h1000, 16'hFFF0, 16'h0003);
    send_frame(16'h8000, 16'h0000, 16'hFFFF, 16'h0000,
               16'h8000, 16'h0C00, 16'hFFF3, 16'h0002);

    // Overrun counting and saturation
    send_overrun_frame(16'h8000, 16'h0C00, 16'hFFF3, 16'h0002);
    check("ovr_one", {24'h0, o_Overrun_Count}, 32'h1);
    for (int i = 0; i < 299; i++) begin
      send_overrun_frame(16'h8000, 16'h0C00, 16'hFFF3, 16'h0002);
    end
    check("ovr_saturated", {24'h0, o_Overrun_Count}, 32'hFF);

    // Watchdog: accept at edge 3 of the frame, stale 99 edges later
    send_frame(16'h8000, 16'h0C00, 16'hFFF3, 16'h0002,
               16'h8000, 16'h0C00, 16'hFFF3, 16'h0002);
    repeat (86) @(negedge i_Clock);
    check("stale_before", {31'h0, o_Stale}, 32'h0);
    @(negedge i_Clock);
    check("stale_at_timeout", {31'h0, o_Stale}, 32'h1);
    repeat (20) @(negedge i_Clock);
    check("stale_held", {31'h0, o_Stale}, 32'h1);
    check("stale_cv1_held", {16'h0, o_CV1}, 32'h0C00);
    check("stale_cv2_held", {16'h0, o_CV2}, 32'hFFF3);

    // Next frame clears stale on its publish
    send_frame(16'h8000, 16'h0C00, 16'hFFF3, 16'h0002,
               16'h8000, 16'h0C00, 16'hFFF3, 16'h0002);
    check("stale_cleared", {31'h0, o_Stale}, 32'h0);

    check("scoreboard_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
